alu_arbiter: RTL

// - Shares the single combinational ALU between two requesters, e.g. integer pipeline (REQ0) and address/branch unit (REQ1).
// - Each requester presents CONTROL/X/Y under a valid/ready handshake.
// - The block selects one request per cycle, drives the ALU and registers RESULTADO/ZERO into a one-entry response buffer.
// - Response carries the requester ID and is drained under valid/ready.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 37 +++
 rtl/alu_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, requester IDs and the request bundle
// used by the ALU arbiter and its users.
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b0100;
    localparam logic [3:0] ALU_SLTU  = 4'b1100;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_XOR   = 4'b1001;
    localparam logic [3:0] ALU_LUI   = 4'b0110;
    localparam logic [3:0] ALU_AUIPC = 4'b0101;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    typedef struct packed {
        logic [3:0]       control;
        logic [ALU_W-1:0] x;
        logic [ALU_W-1:0] y;
    } alu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on ties, or fixed priority to requester 0.
// The last-grant pointer advances only when the granted request is accepted.
module rr_arb2
    import alu_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic       o_gnt_valid,
    output logic       o_gnt_id
);

    logic r_last_grant;

    always_comb begin
        o_gnt_valid = |i_req;
        o_gnt_id    = ID_REQ0;
        if (i_req == 2'b11) begin
            o_gnt_id = (FIXED_PRIO != 0) ? ID_REQ0 : ~r_last_grant;
        end else if (i_req[1]) begin
            o_gnt_id = ID_REQ1;
        end
    end

    // Reset to REQ1 so that the first tie after reset goes to REQ0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= ID_REQ1;
        end else if (i_accept) begin
            r_last_grant <= o_gnt_id;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters and
// registers the result into a one-entry response buffer tagged with the ID.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W          = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         REQ0_VALID,
    output logic         REQ0_READY,
    input  logic [3:0]   REQ0_CONTROL,
    input  logic [W-1:0] REQ0_X,
    input  logic [W-1:0] REQ0_Y,
    input  logic         REQ1_VALID,
    output logic         REQ1_READY,
    input  logic [3:0]   REQ1_CONTROL,
    input  logic [W-1:0] REQ1_X,
    input  logic [W-1:0] REQ1_Y,
    output logic [3:0]   ALU_CONTROL,
    output logic [W-1:0] ALU_X,
    output logic [W-1:0] ALU_Y,
    input  logic [W-1:0] ALU_RESULTADO,
    input  logic         ALU_ZERO,
    output logic         RSP_VALID,
    input  logic         RSP_READY,
    output logic         RSP_ID,
    output logic [W-1:0] RSP_RESULTADO,
    output logic         RSP_ZERO
);

    logic         w_gnt_valid;
    logic         w_gnt_id;
    logic         w_can_accept;
    logic         w_accept;
    logic         r_rsp_valid;
    logic         r_rsp_id;
    logic         r_rsp_zero;
    logic [W-1:0] r_rsp_resultado;

    // Gated by reset so no request is acknowledged while the block is held in reset.
    assign w_can_accept = RST_N && (!r_rsp_valid || RSP_READY);
    assign w_accept     = w_can_accept && w_gnt_valid;

    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .i_clk       (CLK),
        .i_rst_n     (RST_N),
        .i_req       ({REQ1_VALID, REQ0_VALID}),
        .i_accept    (w_accept),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    assign REQ0_READY = w_accept && (w_gnt_id == ID_REQ0);
    assign REQ1_READY = w_accept && (w_gnt_id == ID_REQ1);

    // Idle ALU sees ADD 0+0 so its inputs do not toggle without a grant.
    always_comb begin
        ALU_CONTROL = ALU_ADD;
        ALU_X       = '0;
        ALU_Y       = '0;
        if (w_gnt_valid) begin
            if (w_gnt_id == ID_REQ1) begin
                ALU_CONTROL = REQ1_CONTROL;
                ALU_X       = REQ1_X;
                ALU_Y       = REQ1_Y;
            end else begin
                ALU_CONTROL = REQ0_CONTROL;
                ALU_X       = REQ0_X;
                ALU_Y       = REQ0_Y;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rsp_valid     <= 1'b0;
            r_rsp_id        <= ID_REQ0;
            r_rsp_resultado <= '0;
            r_rsp_zero      <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid     <= 1'b1;
            r_rsp_id        <= w_gnt_id;
            r_rsp_resultado <= ALU_RESULTADO;
            r_rsp_zero      <= ALU_ZERO;
        end else if (RSP_READY) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign RSP_VALID     = r_rsp_valid;
    assign RSP_ID        = r_rsp_id;
    assign RSP_RESULTADO = r_rsp_resultado;
    assign RSP_ZERO      = r_rsp_zero;

endmodule
